// File: rtl/bisr_pkg.sv
// Shared types and constants for the BISR spare allocator.
package bisr_pkg;

  localparam int NUM_PES_DEF    = 16;
  localparam int NUM_SPARES_DEF = 4;
  localparam int ENTRY_PE_W     = $clog2(NUM_PES_DEF);
  localparam int STATS_W        = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    GRANT
  } alloc_state_t;

  // One remap table slot, indexed by spare number.
  typedef struct packed {
    logic                  valid;
    logic [ENTRY_PE_W-1:0] pe_idx;
  } remap_entry_t;

endpackage

// File: rtl/spare_free_finder.sv
// Combinational LSB-priority first-zero finder over the spare busy vector.
module spare_free_finder #(
  parameter int NUM_SPARES  = 4,
  parameter int SPARE_IDX_W = $clog2(NUM_SPARES)
) (
  input  logic [NUM_SPARES-1:0]  spare_busy,
  output logic [SPARE_IDX_W-1:0] free_idx,
  output logic                   any_free
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    free_idx = '0;
    any_free = 1'b0;
    for (int s = NUM_SPARES - 1; s >= 0; s--) begin
      if (!spare_busy[s]) begin
        free_idx = SPARE_IDX_W'(s);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spare_allocator.sv
// Spare allocator: maps faulty PEs to the lowest free spare PE and keeps the
// PE->spare remap table. Optional statistics counters are enabled with the
// SPARE_ALLOC_STATS_EN macro.
module spare_allocator
  import bisr_pkg::*;
#(
  parameter int NUM_PES     = NUM_PES_DEF,
  parameter int NUM_SPARES  = NUM_SPARES_DEF,
  parameter int PE_IDX_W    = $clog2(NUM_PES),
  parameter int SPARE_IDX_W = $clog2(NUM_SPARES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   fault_valid,
  output logic                   fault_ready,
  input  logic [PE_IDX_W-1:0]    fault_pe_idx,
  output logic                   alloc_valid,
  input  logic                   alloc_ready,
  output logic [PE_IDX_W-1:0]    alloc_pe_idx,
  output logic [SPARE_IDX_W-1:0] alloc_spare_idx,
  output logic                   alloc_fail,
  output logic                   alloc_dup,
  output logic [NUM_SPARES-1:0]  spare_busy,
  output logic                   exhausted,
  input  logic [PE_IDX_W-1:0]    lookup_pe_idx,
  output logic                   lookup_hit,
  output logic [SPARE_IDX_W-1:0] lookup_spare_idx
`ifdef SPARE_ALLOC_STATS_EN
  ,
  output logic [STATS_W-1:0]     fault_count,
  output logic [STATS_W-1:0]     fail_count
`endif
);

  localparam logic [PE_IDX_W:0] NUM_PES_L = NUM_PES[PE_IDX_W:0];

  alloc_state_t             state_q, state_d;
  logic [PE_IDX_W-1:0]      pe_q, pe_d;
  logic                     alloc_valid_q, alloc_valid_d;
  logic                     alloc_fail_q, alloc_fail_d;
  logic                     alloc_dup_q, alloc_dup_d;
  logic [SPARE_IDX_W-1:0]   alloc_spare_q, alloc_spare_d;
  logic                     exhausted_q, exhausted_d;
  remap_entry_t             table_q [NUM_SPARES];
  remap_entry_t             table_d [NUM_SPARES];
`ifdef SPARE_ALLOC_STATS_EN
  logic [STATS_W-1:0]       fault_count_q, fault_count_d;
  logic [STATS_W-1:0]       fail_count_q, fail_count_d;
`endif

  logic                     dup_hit;
  logic [SPARE_IDX_W-1:0]   dup_idx;
  logic [SPARE_IDX_W-1:0]   free_idx;
  logic                     any_free;
  logic                     pe_in_range;

  // Busy vector mirrors the valid bits of the table.
  always_comb begin
    spare_busy = '0;
    for (int s = 0; s < NUM_SPARES; s++) spare_busy[s] = table_q[s].valid;
  end

  spare_free_finder #(
    .NUM_SPARES  (NUM_SPARES),
    .SPARE_IDX_W (SPARE_IDX_W)
  ) u_free_finder (
    .spare_busy (spare_busy),
    .free_idx   (free_idx),
    .any_free   (any_free)
  );

  assign pe_in_range = ({1'b0, pe_q} < NUM_PES_L);

  // CAM compare of the registered fault PE against the live table entries.
  always_comb begin
    dup_hit = 1'b0;
    dup_idx = '0;
    for (int s = 0; s < NUM_SPARES; s++) begin
      if (table_q[s].valid && (table_q[s].pe_idx == ENTRY_PE_W'(pe_q))) begin
        dup_hit = 1'b1;
        dup_idx = SPARE_IDX_W'(s);
      end
    end
  end

  // Datapath lookup CAM; at most one entry can match since dups are never written.
  always_comb begin
    lookup_hit       = 1'b0;
    lookup_spare_idx = '0;
    for (int s = 0; s < NUM_SPARES; s++) begin
      if (table_q[s].valid && (table_q[s].pe_idx == ENTRY_PE_W'(lookup_pe_idx))) begin
        lookup_hit       = 1'b1;
        lookup_spare_idx = SPARE_IDX_W'(s);
      end
    end
  end

  // Next-state, table update and grant result computation.
  always_comb begin
    state_d       = state_q;
    pe_d          = pe_q;
    alloc_valid_d = alloc_valid_q;
    alloc_fail_d  = alloc_fail_q;
    alloc_dup_d   = alloc_dup_q;
    alloc_spare_d = alloc_spare_q;
    exhausted_d   = exhausted_q;
    table_d       = table_q;
`ifdef SPARE_ALLOC_STATS_EN
    fault_count_d = fault_count_q;
    fail_count_d  = fail_count_q;
`endif

    if (clear) begin
      // Soft clear wins over any handshake in the same cycle.
      state_d       = IDLE;
      alloc_valid_d = 1'b0;
      alloc_fail_d  = 1'b0;
      alloc_dup_d   = 1'b0;
      exhausted_d   = 1'b0;
      for (int s = 0; s < NUM_SPARES; s++) table_d[s] = '0;
`ifdef SPARE_ALLOC_STATS_EN
      fault_count_d = '0;
      fail_count_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fault_valid) begin
            pe_d    = fault_pe_idx;
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          state_d       = GRANT;
          alloc_valid_d = 1'b1;
          alloc_fail_d  = 1'b0;
          alloc_dup_d   = 1'b0;
          alloc_spare_d = '0;
          if (!pe_in_range) begin
            // Bogus index: report failure but do not mark the pool exhausted.
            alloc_fail_d = 1'b1;
          end else if (dup_hit) begin
            alloc_dup_d   = 1'b1;
            alloc_spare_d = dup_idx;
          end else if (any_free) begin
            table_d[free_idx] = '{valid: 1'b1, pe_idx: ENTRY_PE_W'(pe_q)};
            alloc_spare_d     = free_idx;
          end else begin
            alloc_fail_d = 1'b1;
            exhausted_d  = 1'b1;
          end
`ifdef SPARE_ALLOC_STATS_EN
          if (fault_count_q != '1) fault_count_d = fault_count_q + 1'b1;
          if (alloc_fail_d && (fail_count_q != '1)) fail_count_d = fail_count_q + 1'b1;
`endif
        end
        GRANT: begin
          if (alloc_ready) begin
            alloc_valid_d = 1'b0;
            alloc_fail_d  = 1'b0;
            alloc_dup_d   = 1'b0;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q       <= IDLE;
      pe_q          <= '0;
      alloc_valid_q <= 1'b0;
      alloc_fail_q  <= 1'b0;
      alloc_dup_q   <= 1'b0;
      alloc_spare_q <= '0;
      exhausted_q   <= 1'b0;
      // NOTE: the table is reset because its valid bits define the free pool; it is tiny, so flops are cheap.
      for (int s = 0; s < NUM_SPARES; s++) table_q[s] <= '0;
`ifdef SPARE_ALLOC_STATS_EN
      fault_count_q <= '0;
      fail_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pe_q          <= pe_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_fail_q  <= alloc_fail_d;
      alloc_dup_q   <= alloc_dup_d;
      alloc_spare_q <= alloc_spare_d;
      exhausted_q   <= exhausted_d;
      table_q       <= table_d;
`ifdef SPARE_ALLOC_STATS_EN
      fault_count_q <= fault_count_d;
      fail_count_q  <= fail_count_d;
`endif
    end
  end

  assign fault_ready     = (state_q == IDLE);
  assign alloc_valid     = alloc_valid_q;
  assign alloc_fail      = alloc_fail_q;
  assign alloc_dup       = alloc_dup_q;
  assign alloc_pe_idx    = pe_q;
  assign alloc_spare_idx = alloc_spare_q;
  assign exhausted       = exhausted_q;
`ifdef SPARE_ALLOC_STATS_EN
  assign fault_count     = fault_count_q;
  assign fail_count      = fail_count_q;
`endif

endmodule
